regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_pkg.sv | 16 +
 rtl/regfile_bypass_mux.sv | 15 +
 rtl/regfile_scoreboard.sv | 118 +++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared width constants and helpers for the register file / scoreboard slice.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package regfile_scoreboard_pkg;

    localparam int RF_XLEN = 64;
    localparam int RF_NREG = 32;
    localparam int RF_NRD  = 2;
    localparam int RF_NWR  = 2;

    // Index width for a register file of n entries (n is a power of two).
    function automatic int rf_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port selector: forwarded writeback data or stored array data.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module regfile_bypass_mux #(
    parameter int XLEN = 64
) (
    input  logic            fwd_vld_i,
    input  logic [XLEN-1:0] fwd_dat_i,
    input  logic [XLEN-1:0] arr_dat_i,
    output logic [XLEN-1:0] rd_dat_o
);

    assign rd_dat_o = fwd_vld_i ? fwd_dat_i : arr_dat_i;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write bypass and per-register pending-producer busy bits.
// Latency: reads zero-cycle (combinational, with bypass); writes, busy bits and busy_cnt update at next clk edge.
// Backpressure: none; every write, issue and flush is accepted every cycle.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter  int XLEN = RF_XLEN,
    parameter  int NREG = RF_NREG,
    parameter  int NRD  = RF_NRD,
    parameter  int NWR  = RF_NWR,
    localparam int AW   = rf_aw(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      wb_en,
    input  logic [NWR*AW-1:0]   wb_idx,
    input  logic [NWR*XLEN-1:0] wb_data,
    input  logic [NRD*AW-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_idx,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     busy_cnt_q;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Array commit: ports visited in ascending order so the highest-numbered port's write lands last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wb_en[k] && (wb_idx[k*AW +: AW] != '0)) begin
                    regs_q[wb_idx[k*AW +: AW]] <= wb_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Next busy vector: writebacks clear, a new issue re-sets (new producer wins), flush overrides all; x0 never busy.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (wb_en[k]) begin
                busy_d[wb_idx[k*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en) begin
            busy_d[iss_idx] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Busy bits and their registered population count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= popcount(busy_d);
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   idx;
        logic            fwd_vld;
        logic [XLEN-1:0] fwd_dat;

        assign idx = rd_idx[p*AW +: AW];

        // Forwarding hit for this read port; the last matching (highest-numbered) write port wins.
        always_comb begin
            fwd_vld = 1'b0;
            fwd_dat = '0;
            for (int k = 0; k < NWR; k++) begin
                if (wb_en[k] && (wb_idx[k*AW +: AW] == idx) && (idx != '0)) begin
                    fwd_vld = 1'b1;
                    fwd_dat = wb_data[k*XLEN +: XLEN];
                end
            end
        end

        regfile_bypass_mux #(
            .XLEN (XLEN)
        ) u_bypass_mux (
            .fwd_vld_i (fwd_vld),
            .fwd_dat_i (fwd_dat),
            .arr_dat_i (regs_q[idx]),
            .rd_dat_o  (rd_data[p*XLEN +: XLEN])
        );

        // A same-cycle writeback resolves the pending producer, so the port reports not-busy.
        assign rd_busy[p] = busy_q[idx] & ~fwd_vld;
    end

endmodule
